// File: rtl/matrix_3x3_gen.sv
// Purpose: builds a 3x3 pixel neighbourhood from a raster pixel stream using two
//          chained line buffers and three 3-deep column shift registers.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   per_frame_vsync/href/clken  input frame sync, line valid, pixel strobe
//   per_img_data[DW-1:0]        input pixel
//   matrix_frame_vsync/href     inputs delayed by one clock
//   matrix_frame_clken          one-cycle window-valid pulse per accepted pixel
//   win_row1/2/3[3*DW-1:0]      rows two lines back / one line back / current;
//                               [3DW-1:2DW] oldest column, [DW-1:0] newest
module matrix_3x3_gen #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned DW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            per_frame_vsync,
  input  logic            per_frame_href,
  input  logic            per_frame_clken,
  input  logic [DW-1:0]   per_img_data,
  output logic            matrix_frame_vsync,
  output logic            matrix_frame_href,
  output logic            matrix_frame_clken,
  output logic [3*DW-1:0] win_row1,
  output logic [3*DW-1:0] win_row2,
  output logic [3*DW-1:0] win_row3
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned WW = 3 * DW;

  logic          r_vsync_d;
  logic          r_href_d;
  logic          r_clken;
  logic [AW-1:0] r_col;
  logic [1:0]    r_line;
  logic [WW-1:0] r_row1;
  logic [WW-1:0] r_row2;
  logic [WW-1:0] r_row3;
  logic [DW-1:0] r_buf1 [IMG_W];
  logic [DW-1:0] r_buf2 [IMG_W];

  logic          w_vsync_rise;
  logic          w_href_rise;
  logic          w_href_fall;
  logic          w_accept;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_col_nxt;
  logic [1:0]    w_line;
  logic [DW-1:0] w_old_a;
  logic [DW-1:0] w_old_b;
  logic [DW-1:0] w_new_r1;
  logic [DW-1:0] w_new_r2;
  logic [WW-1:0] w_base1;
  logic [WW-1:0] w_base2;
  logic [WW-1:0] w_base3;

  // Edge detection, accept qualification and column/line values seen by this cycle.
  // A pixel may arrive on the href rising edge itself, so the clears are folded
  // into the values used for that same accept.
  always_comb begin
    w_vsync_rise = per_frame_vsync & ~r_vsync_d;
    w_href_rise  = per_frame_href  & ~r_href_d;
    w_href_fall  = ~per_frame_href &  r_href_d;
    w_accept     = per_frame_href  &  per_frame_clken;

    w_col     = w_href_rise ? '0 : r_col;
    w_col_nxt = (w_col == AW'(IMG_W - 1)) ? '0 : w_col + AW'(1);
    w_line    = w_vsync_rise ? 2'd0 : r_line;

    // Read-before-write: old contents are read combinationally in the accept cycle.
    w_old_a = r_buf1[w_col];
    w_old_b = r_buf2[w_col];

    // Stale lines from a previous frame are masked until enough lines have arrived.
    w_new_r2 = (w_line >= 2'd1) ? w_old_a : '0;
    w_new_r1 = (w_line >= 2'd2) ? w_old_b : '0;

    w_base1 = w_href_rise ? '0 : r_row1;
    w_base2 = w_href_rise ? '0 : r_row2;
    w_base3 = w_href_rise ? '0 : r_row3;
  end

  // Control, counters and window shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_clken   <= 1'b0;
      r_col     <= '0;
      r_line    <= 2'd0;
      r_row1    <= '0;
      r_row2    <= '0;
      r_row3    <= '0;
    end else begin
      r_vsync_d <= per_frame_vsync;
      r_href_d  <= per_frame_href;
      r_clken   <= w_accept;

      if (w_vsync_rise) begin
        r_line <= 2'd0;
      end else if (w_href_fall && (r_line != 2'd2)) begin
        r_line <= r_line + 2'd1;
      end

      if (w_accept) begin
        r_col  <= w_col_nxt;
        r_row1 <= {w_base1[2*DW-1:0], w_new_r1};
        r_row2 <= {w_base2[2*DW-1:0], w_new_r2};
        r_row3 <= {w_base3[2*DW-1:0], per_img_data};
      end else if (w_href_rise) begin
        r_col  <= '0;
        r_row1 <= '0;
        r_row2 <= '0;
        r_row3 <= '0;
      end
    end
  end

  // Line buffers (contents not reset); buffer2 receives what buffer1 held.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf1[w_col] <= per_img_data;
      r_buf2[w_col] <= w_old_a;
    end
  end

  assign matrix_frame_vsync = r_vsync_d;
  assign matrix_frame_href  = r_href_d;
  assign matrix_frame_clken = r_clken;
  assign win_row1           = r_row1;
  assign win_row2           = r_row2;
  assign win_row3           = r_row3;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Purpose: directed self-checking bench for matrix_3x3_gen with IMG_W=4, DW=8.
module tb_matrix_3x3_gen;

  logic        clk;
  logic        rst_n;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [7:0]  per_img_data;
  logic        matrix_frame_vsync;
  logic        matrix_frame_href;
  logic        matrix_frame_clken;
  logic [23:0] win_row1;
  logic [23:0] win_row2;
  logic [23:0] win_row3;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  matrix_3x3_gen #(.IMG_W(4), .DW(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .per_frame_vsync   (per_frame_vsync),
    .per_frame_href    (per_frame_href),
    .per_frame_clken   (per_frame_clken),
    .per_img_data      (per_img_data),
    .matrix_frame_vsync(matrix_frame_vsync),
    .matrix_frame_href (matrix_frame_href),
    .matrix_frame_clken(matrix_frame_clken),
    .win_row1          (win_row1),
    .win_row2          (win_row2),
    .win_row3          (win_row3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] p3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; return 1 time unit after the rising edge.
  task automatic pix(input logic vs, input logic hr, input logic ce, input logic [7:0] d);
    @(negedge clk);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_data    = d;
    @(posedge clk);
    #1;
    if (matrix_frame_clken === 1'b1) n_pulses++;
  endtask

  // One accepted pixel inside a frame, then check the resulting window.
  task automatic acc(input string tag, input logic [7:0] d,
                     input logic [23:0] e1, input logic [23:0] e2, input logic [23:0] e3);
    pix(1'b1, 1'b1, 1'b1, d);
    chk({tag, "_clken"}, 32'(matrix_frame_clken), 32'd1);
    chk({tag, "_row1"},  32'(win_row1), 32'(e1));
    chk({tag, "_row2"},  32'(win_row2), 32'(e2));
    chk({tag, "_row3"},  32'(win_row3), 32'(e3));
  endtask

  task automatic idle2();
    pix(1'b1, 1'b0, 1'b0, 8'd0);
    pix(1'b1, 1'b0, 1'b0, 8'd0);
    chk("idle_clken", 32'(matrix_frame_clken), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_data    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vsync", 32'(matrix_frame_vsync), 32'd0);
    chk("rst_href",  32'(matrix_frame_href),  32'd0);
    chk("rst_clken", 32'(matrix_frame_clken), 32'd0);
    chk("rst_row3",  32'(win_row3), 32'd0);

    // Partial line, then reset asserted mid-line.
    @(negedge clk);
    rst_n = 1'b1;
    pix(1'b1, 1'b0, 1'b0, 8'd0);
    chk("vsync_dly", 32'(matrix_frame_vsync), 32'd1);
    pix(1'b1, 1'b1, 1'b1, 8'hAA);
    pix(1'b1, 1'b1, 1'b1, 8'hBB);
    chk("pre_rst_row3", 32'(win_row3), 32'(p3(8'd0, 8'hAA, 8'hBB)));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_row3",  32'(win_row3), 32'd0);
    chk("arst_href",  32'(matrix_frame_href), 32'd0);
    chk("arst_vsync", 32'(matrix_frame_vsync), 32'd0);
    chk("arst_clken", 32'(matrix_frame_clken), 32'd0);
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: vsync rising edge then lines.
    pix(1'b0, 1'b0, 1'b0, 8'd0);
    pix(1'b1, 1'b0, 1'b0, 8'd0);
    acc("l0p0", 8'd1, 24'd0, 24'd0, p3(0, 0, 1));
    chk("href_dly", 32'(matrix_frame_href), 32'd1);
    acc("l0p1", 8'd2, 24'd0, 24'd0, p3(0, 1, 2));
    acc("l0p2", 8'd3, 24'd0, 24'd0, p3(1, 2, 3));
    acc("l0p3", 8'd4, 24'd0, 24'd0, p3(2, 3, 4));
    idle2();

    acc("l1p0", 8'd5, 24'd0, p3(0, 0, 1), p3(0, 0, 5));
    acc("l1p1", 8'd6, 24'd0, p3(0, 1, 2), p3(0, 5, 6));
    acc("l1p2", 8'd7, 24'd0, p3(1, 2, 3), p3(5, 6, 7));
    acc("l1p3", 8'd8, 24'd0, p3(2, 3, 4), p3(6, 7, 8));
    idle2();

    acc("l2p0", 8'd9,  p3(0, 0, 1), p3(0, 0, 5), p3(0, 0, 9));
    acc("l2p1", 8'd10, p3(0, 1, 2), p3(0, 5, 6), p3(0, 9, 10));
    acc("l2p2", 8'd11, p3(1, 2, 3), p3(5, 6, 7), p3(9, 10, 11));
    acc("l2p3", 8'd12, p3(2, 3, 4), p3(6, 7, 8), p3(10, 11, 12));
    idle2();

    // Strobe gaps: clken 1,0,0,1 within href; line count saturated at 2.
    n_pulses = 0;
    acc("l3p0", 8'd13, p3(0, 0, 5), p3(0, 0, 9), p3(0, 0, 13));
    pix(1'b1, 1'b1, 1'b0, 8'd99);
    chk("gap1_clken", 32'(matrix_frame_clken), 32'd0);
    chk("gap1_row3",  32'(win_row3), 32'(p3(0, 0, 13)));
    pix(1'b1, 1'b1, 1'b0, 8'd98);
    chk("gap2_clken", 32'(matrix_frame_clken), 32'd0);
    chk("gap2_row2",  32'(win_row2), 32'(p3(0, 0, 9)));
    acc("l3p1", 8'd14, p3(0, 5, 6), p3(0, 9, 10), p3(0, 13, 14));
    idle2();
    chk("gap_pulses", 32'(n_pulses), 32'd2);

    // New frame: stale RAM masked; 6-pixel line wraps the address.
    pix(1'b0, 1'b0, 1'b0, 8'd0);
    pix(1'b1, 1'b0, 1'b0, 8'd0);
    acc("f2l0p0", 8'd20, 24'd0, 24'd0, p3(0, 0, 20));
    acc("f2l0p1", 8'd21, 24'd0, 24'd0, p3(0, 20, 21));
    acc("f2l0p2", 8'd22, 24'd0, 24'd0, p3(20, 21, 22));
    acc("f2l0p3", 8'd23, 24'd0, 24'd0, p3(21, 22, 23));
    acc("f2l0p4", 8'd24, 24'd0, 24'd0, p3(22, 23, 24));
    acc("f2l0p5", 8'd25, 24'd0, 24'd0, p3(23, 24, 25));
    idle2();

    // Addresses 0-1 now hold 24,25; addresses 2-3 still hold 22,23.
    acc("f2l1p0", 8'd30, 24'd0, p3(0, 0, 24),   p3(0, 0, 30));
    acc("f2l1p1", 8'd31, 24'd0, p3(0, 24, 25),  p3(0, 30, 31));
    acc("f2l1p2", 8'd32, 24'd0, p3(24, 25, 22), p3(30, 31, 32));
    acc("f2l1p3", 8'd33, 24'd0, p3(25, 22, 23), p3(31, 32, 33));
    idle2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
